// File: rtl/buf_mover_pkg.sv
// buf_mover_pkg: shared state encoding and default parameter values for buf_mover.
package buf_mover_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int DATA_W_DEF = 128;
    localparam int ADDR_W_DEF = 32;
    localparam int NUM_W_DEF  = 8;
    localparam int DEPTH_DEF  = 4;
endpackage

// File: rtl/buf_mover_if.sv
// buf_mover_if: command, read and write ports of buf_mover; master is the mover side.
interface buf_mover_if
    import buf_mover_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_W  = NUM_W_DEF
);
    logic              MOVE_START;
    logic [NUM_W-1:0]  MOVE_NUM;
    logic [ADDR_W-1:0] SOURCE_ADDR;
    logic [ADDR_W-1:0] DEST_ADDR;
    logic [ADDR_W-1:0] SRC_STRIDE;
    logic [ADDR_W-1:0] DST_STRIDE;
    logic              MOVE_BUSY;
    logic              MOVE_DONE;
    logic              RD_START;
    logic [ADDR_W-1:0] RD_ADDR;
    logic [DATA_W-1:0] RD_DATA;
    logic              RD_DONE;
    logic              WR_START;
    logic [ADDR_W-1:0] WR_ADDR;
    logic [DATA_W-1:0] WR_DATA;
    logic              WR_DONE;

    modport master (
        input  MOVE_START, MOVE_NUM, SOURCE_ADDR, DEST_ADDR, SRC_STRIDE, DST_STRIDE,
        input  RD_DATA, RD_DONE, WR_DONE,
        output MOVE_BUSY, MOVE_DONE, RD_START, RD_ADDR, WR_START, WR_ADDR, WR_DATA
    );
    modport slave (
        output MOVE_START, MOVE_NUM, SOURCE_ADDR, DEST_ADDR, SRC_STRIDE, DST_STRIDE,
        output RD_DATA, RD_DONE, WR_DONE,
        input  MOVE_BUSY, MOVE_DONE, RD_START, RD_ADDR, WR_START, WR_ADDR, WR_DATA
    );
endinterface

// File: rtl/buf_mover_fifo.sv
// buf_mover_fifo: DEPTH x DATA_W buffer without bypass; exposes the head and the entry behind it.
module buf_mover_fifo #(
    parameter int DATA_W = 128,
    parameter int DEPTH  = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [AW:0]       count,
    output logic [DATA_W-1:0] head,
    output logic [DATA_W-1:0] nxt
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wp, rp;

    assign head = mem[rp];
    assign nxt  = mem[rp + AW'(1)];

    always_ff @(posedge ACLK)
        if (push) mem[wp] <= din;

    always_ff @(posedge ACLK or negedge ARESETN)
        if (!ARESETN) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            wp    <= wp + AW'(push);
            rp    <= rp + AW'(pop);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
endmodule

// File: rtl/buf_mover.sv
// buf_mover: multi-beat memory mover with decoupled read/write engines and a DEPTH-entry buffer.
// Define BUF_MOVER_STRIDE_EN to use the SRC_STRIDE/DST_STRIDE values latched at MOVE_START.
module buf_mover
    import buf_mover_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_W  = NUM_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input logic       ACLK,
    input logic       ARESETN,
    buf_mover_if.master bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    state_t            state, state_n;
    logic [NUM_W-1:0]  num, rd_cnt, wr_cnt;
    logic [ADDR_W-1:0] rd_addr, wr_addr, src_step, dst_step;
    logic [DATA_W-1:0] wr_data, head, nxt;
    logic [CW-1:0]     count, count_n;
    logic              rd_pend, wr_pend, rd_start, wr_start;
    logic              go, push, pop, last, rd_issue, wr_issue;

    buf_mover_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
        .ACLK(ACLK), .ARESETN(ARESETN), .push(push), .pop(pop),
        .din(bus.RD_DATA), .count(count), .head(head), .nxt(nxt)
    );

    assign go      = state == IDLE && bus.MOVE_START;
    assign push    = bus.RD_DONE && rd_pend;
    assign pop     = bus.WR_DONE && wr_pend;
    assign last    = pop && wr_cnt == num - NUM_W'(1);
    assign count_n = count + CW'(push) - CW'(pop);
    // Issue decisions look at the post-edge occupancy so a completing beat frees its slot at once.
    assign rd_issue = go ? bus.MOVE_NUM != '0
                         : state == RUN && rd_cnt != num && (!rd_pend || push) && count_n < CW'(DEPTH);
    assign wr_issue = state == RUN && (!wr_pend || pop) && count_n != '0;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (bus.MOVE_START) state_n = bus.MOVE_NUM == '0 ? DONE : RUN;
            RUN:     if (last) state_n = DONE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN)
        if (!ARESETN) begin
            state    <= IDLE;
            num      <= '0;
            rd_cnt   <= '0;
            wr_cnt   <= '0;
            rd_pend  <= 1'b0;
            wr_pend  <= 1'b0;
            rd_start <= 1'b0;
            wr_start <= 1'b0;
            rd_addr  <= '0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else begin
            state    <= state_n;
            rd_start <= rd_issue;
            wr_start <= wr_issue;
            rd_pend  <= rd_issue || (rd_pend && !push);
            wr_pend  <= wr_issue || (wr_pend && !pop);
            if (go) begin
                num     <= bus.MOVE_NUM;
                rd_cnt  <= NUM_W'(rd_issue);
                wr_cnt  <= '0;
                rd_addr <= bus.SOURCE_ADDR;
                wr_addr <= bus.DEST_ADDR;
            end else begin
                rd_cnt <= rd_cnt + NUM_W'(rd_issue);
                wr_cnt <= wr_cnt + NUM_W'(pop);
                if (push) rd_addr <= rd_addr + src_step;
                if (pop) wr_addr <= wr_addr + dst_step;
            end
            // Load the beat that will be at the buffer head after this edge's push/pop.
            if (wr_issue) wr_data <= pop ? (count > CW'(1) ? nxt : bus.RD_DATA)
                                         : (count != '0 ? head : bus.RD_DATA);
        end

`ifdef BUF_MOVER_STRIDE_EN
    always_ff @(posedge ACLK or negedge ARESETN)
        if (!ARESETN) {src_step, dst_step} <= '0;
        else if (go) {src_step, dst_step} <= {bus.SRC_STRIDE, bus.DST_STRIDE};
`else
    assign src_step = ADDR_W'(DATA_W / 8);
    assign dst_step = ADDR_W'(DATA_W / 8);
`endif

    assign bus.MOVE_BUSY = state != IDLE;
    assign bus.MOVE_DONE = state == DONE;
    assign bus.RD_START  = rd_start;
    assign bus.RD_ADDR   = rd_addr;
    assign bus.WR_START  = wr_start;
    assign bus.WR_ADDR   = wr_addr;
    assign bus.WR_DATA   = wr_data;
endmodule

// File: tb/tb_buf_mover.sv
// tb_buf_mover: directed bench for buf_mover with latency-configurable read/write responders.
module tb_buf_mover;
    logic ACLK = 1'b0;
    logic ARESETN = 1'b0;
    always #5 ACLK = ~ACLK;

    buf_mover_if bus ();
    buf_mover dut (.ACLK(ACLK), .ARESETN(ARESETN), .bus(bus));

    int n_cmp = 0, n_bad = 0;
    int cyc = 0, n_rs, n_rd, n_ws, n_wd, n_md, md_cyc, last_wd_cyc, first_rd_cyc, first_ws_cyc;
    int rd_lat = 1, wr_lat = 1, rd_wait = 0, wr_wait = 0;
    logic wr_hold = 1'b0;
    logic [31:0]  rd_log [16];
    logic [31:0]  wa_log [16];
    logic [127:0] wd_log [16];

    function automatic logic [127:0] pat(logic [31:0] a);
        return {a, ~a, a ^ 32'h1234_5678, a + 32'h9E37_79B9};
    endfunction

    task automatic tick();
        @(negedge ACLK);
        #1;
    endtask

    task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        n_rs = 0; n_rd = 0; n_ws = 0; n_wd = 0; n_md = 0;
        md_cyc = -1; last_wd_cyc = -1; first_rd_cyc = -1; first_ws_cyc = -1;
    endtask

    task automatic start(logic [7:0] num, logic [31:0] src, logic [31:0] dst);
        bus.MOVE_NUM = num;
        bus.SOURCE_ADDR = src;
        bus.DEST_ADDR = dst;
        bus.MOVE_START = 1'b1;
        tick();
        bus.MOVE_START = 1'b0;
    endtask

    task automatic wait_done(string tag);
        for (int i = 0; i < 400 && n_md == 0; i++) tick();
        tick();
        tick();
        chk({tag, "_done_pulses"}, n_md, 1);
        chk({tag, "_idle_after"}, bus.MOVE_BUSY, 0);
    endtask

    // Responders and monitor: complete each request rd_lat/wr_lat cycles after its START.
    initial begin
        bus.RD_DONE = 1'b0;
        bus.WR_DONE = 1'b0;
        bus.RD_DATA = {4{32'hDEAD_BEEF}};
        forever begin
            @(negedge ACLK);
            cyc++;
            bus.RD_DONE = 1'b0;
            bus.WR_DONE = 1'b0;
            bus.RD_DATA = {4{32'hDEAD_BEEF}};
            if (bus.MOVE_DONE) begin n_md++; md_cyc = cyc; end
            if (bus.RD_START) begin
                if (n_rs < 16) rd_log[n_rs] = bus.RD_ADDR;
                n_rs++;
                rd_wait = rd_lat + 1;
            end
            if (bus.WR_START) begin
                if (n_ws == 0) first_ws_cyc = cyc;
                n_ws++;
                wr_wait = wr_lat + 1;
            end
            if (rd_wait > 0) begin
                rd_wait--;
                if (rd_wait == 0) begin
                    bus.RD_DONE = 1'b1;
                    bus.RD_DATA = pat(bus.RD_ADDR);
                    if (n_rd == 0) first_rd_cyc = cyc;
                    n_rd++;
                end
            end
            if (wr_wait > 0 && !wr_hold) begin
                wr_wait--;
                if (wr_wait == 0) begin
                    bus.WR_DONE = 1'b1;
                    if (n_wd < 16) begin wa_log[n_wd] = bus.WR_ADDR; wd_log[n_wd] = bus.WR_DATA; end
                    n_wd++;
                    last_wd_cyc = cyc;
                end
            end
        end
    end

    initial begin
        bus.MOVE_START = 1'b0;
        bus.MOVE_NUM = '0;
        bus.SOURCE_ADDR = '0;
        bus.DEST_ADDR = '0;
        bus.SRC_STRIDE = 32'h10;
        bus.DST_STRIDE = 32'h10;
        clr();
        tick();
        chk("rst_busy", bus.MOVE_BUSY, 0);
        chk("rst_done", bus.MOVE_DONE, 0);
        chk("rst_rd_start", bus.RD_START, 0);
        chk("rst_wr_start", bus.WR_START, 0);
        chk("rst_rd_addr", bus.RD_ADDR, 0);
        chk("rst_wr_addr", bus.WR_ADDR, 0);
        chk("rst_wr_data", bus.WR_DATA, 0);
        ARESETN = 1'b1;
        tick();

        // Three contiguous beats, one-cycle responders
        clr();
        start(3, 32'h100, 32'h800);
        chk("t1_busy", bus.MOVE_BUSY, 1);
        chk("t1_rd_start", bus.RD_START, 1);
        wait_done("t1");
        chk("t1_reads", n_rs, 3);
        chk("t1_writes", n_ws, 3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t1_rd_addr%0d", i), rd_log[i], 32'h100 + 32'h10 * i);
            chk($sformatf("t1_wr_addr%0d", i), wa_log[i], 32'h800 + 32'h10 * i);
            chk($sformatf("t1_wr_data%0d", i), wd_log[i], pat(32'h100 + 32'h10 * i));
        end
        chk("t1_first_wr_latency", first_ws_cyc, first_rd_cyc + 1);
        chk("t1_done_latency", md_cyc, last_wd_cyc + 1);

        // Zero-beat move
        clr();
        start(0, 32'h100, 32'h800);
        chk("t2_done", bus.MOVE_DONE, 1);
        chk("t2_busy", bus.MOVE_BUSY, 1);
        tick();
        chk("t2_done_drop", bus.MOVE_DONE, 0);
        chk("t2_idle", bus.MOVE_BUSY, 0);
        repeat (3) tick();
        chk("t2_no_reads", n_rs, 0);
        chk("t2_no_writes", n_ws, 0);

        // Eight beats with writes withheld; a start while busy must be ignored
        clr();
        wr_hold = 1'b1;
        start(8, 32'h400, 32'hC00);
        repeat (3) tick();
        bus.MOVE_NUM = 8'd1;
        bus.SOURCE_ADDR = 32'hAAA0;
        bus.DEST_ADDR = 32'hBBB0;
        bus.MOVE_START = 1'b1;
        tick();
        bus.MOVE_START = 1'b0;
        repeat (16) tick();
        chk("t3_reads_done_stalled", n_rd, 4);
        chk("t3_reads_issued_stalled", n_rs, 4);
        chk("t3_one_write_pending", n_ws, 1);
        wr_hold = 1'b0;
        wait_done("t3");
        chk("t3_reads", n_rs, 8);
        chk("t3_writes", n_wd, 8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t3_wr_addr%0d", i), wa_log[i], 32'hC00 + 32'h10 * i);
            chk($sformatf("t3_wr_data%0d", i), wd_log[i], pat(32'h400 + 32'h10 * i));
        end

        // Address wrap with zero-latency responders
        rd_lat = 0;
        wr_lat = 0;
        clr();
        start(2, 32'hFFFF_FFF0, 32'h1000);
        wait_done("t4");
        chk("t4_rd_addr0", rd_log[0], 32'hFFFF_FFF0);
        chk("t4_rd_addr1_wrap", rd_log[1], 32'h0);
        chk("t4_wr_addr1", wa_log[1], 32'h1010);
        chk("t4_wr_data0", wd_log[0], pat(32'hFFFF_FFF0));
        chk("t4_wr_data1", wd_log[1], pat(32'h0));

        // Reset mid-move with a write outstanding, then a stray WR_DONE
        rd_lat = 1;
        wr_lat = 1;
        clr();
        wr_hold = 1'b1;
        start(4, 32'h200, 32'h300);
        repeat (8) tick();
        chk("t5_write_outstanding", n_ws, 1);
        ARESETN = 1'b0;
        #1;
        chk("t5_rst_busy", bus.MOVE_BUSY, 0);
        chk("t5_rst_done", bus.MOVE_DONE, 0);
        chk("t5_rst_rd_start", bus.RD_START, 0);
        chk("t5_rst_wr_start", bus.WR_START, 0);
        chk("t5_rst_rd_addr", bus.RD_ADDR, 0);
        chk("t5_rst_wr_addr", bus.WR_ADDR, 0);
        chk("t5_rst_wr_data", bus.WR_DATA, 0);
        tick();
        ARESETN = 1'b1;
        clr();
        wr_hold = 1'b0;
        repeat (5) tick();
        chk("t5_stray_busy", bus.MOVE_BUSY, 0);
        chk("t5_stray_no_wr", n_ws, 0);
        chk("t5_stray_no_rd", n_rs, 0);
        chk("t5_stray_no_done", n_md, 0);
        clr();
        start(1, 32'h40, 32'h80);
        wait_done("t5");
        chk("t5_writes", n_ws, 1);
        chk("t5_wr_addr", wa_log[0], 32'h80);
        chk("t5_wr_data", wd_log[0], pat(32'h40));

`ifdef BUF_MOVER_STRIDE_EN
        // Programmable strides: 0x40 on reads, 0 on writes
        clr();
        bus.SRC_STRIDE = 32'h40;
        bus.DST_STRIDE = 32'h0;
        start(3, 32'h1000, 32'h2000);
        wait_done("t6");
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t6_rd_addr%0d", i), rd_log[i], 32'h1000 + 32'h40 * i);
            chk($sformatf("t6_wr_addr%0d", i), wa_log[i], 32'h2000);
            chk($sformatf("t6_wr_data%0d", i), wd_log[i], pat(32'h1000 + 32'h40 * i));
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/buf_mover.md
# buf_mover

Parametrised successor to the single-beat memory mover in the accelerator's data path. Copies `MOVE_NUM` data beats from `SOURCE_ADDR` to `DEST_ADDR` using the same start/done read and write request ports. Read and write engines are decoupled by an internal `DEPTH`-entry buffer, so reads run ahead of writes. Sits between the controller that issues move commands and the memory-side read/write adapters.

## Interface

Parameters:
- `DATA_W`, 128: beat width in bits; a multiple of 8.
- `ADDR_W`, 32: byte address width.
- `NUM_W`, 8: width of the beat count.
- `DEPTH`, 4: buffer entries; a power of 2, at least 2.

Ports:
- `ACLK` in 1: the single clock. All logic is rising-edge.
- `ARESETN` in 1: asynchronous, active-low reset.
- `MOVE_START` in 1: command pulse. Accepted only in IDLE.
- `MOVE_NUM` in `NUM_W`: number of beats. Sampled with `MOVE_START`.
- `SOURCE_ADDR` in `ADDR_W`: first read byte address. Sampled with `MOVE_START`.
- `DEST_ADDR` in `ADDR_W`: first write byte address. Sampled with `MOVE_START`.
- `SRC_STRIDE` in `ADDR_W`: read address increment in bytes. Used only with `BUF_MOVER_STRIDE_EN`.
- `DST_STRIDE` in `ADDR_W`: write address increment in bytes. Used only with `BUF_MOVER_STRIDE_EN`.
- `MOVE_BUSY` out 1: high while not IDLE.
- `MOVE_DONE` out 1: one-cycle completion pulse.
- `RD_START` out 1: one-cycle read request pulse.
- `RD_ADDR` out `ADDR_W`: read address. Held from `RD_START` until `RD_DONE`.
- `RD_DATA` in `DATA_W`: read data. Valid only while `RD_DONE` is high.
- `RD_DONE` in 1: read completion pulse.
- `WR_START` out 1: one-cycle write request pulse.
- `WR_ADDR` out `ADDR_W`: write address. Held from `WR_START` until `WR_DONE`.
- `WR_DATA` out `DATA_W`: write data. Held from `WR_START` until `WR_DONE`.
- `WR_DONE` in 1: write completion pulse.

## Operation

- States are IDLE, RUN and DONE.
- IDLE→RUN: on `MOVE_START` with `MOVE_NUM` ≠ 0.
  - Latches the addresses, strides and count.
  - Clears the read and write beat counters.
- IDLE→DONE: on `MOVE_START` with `MOVE_NUM` = 0. No bus transactions are issued.
- RUN→DONE: on the `WR_DONE` that completes beat `MOVE_NUM`.
- DONE→IDLE: unconditional after one cycle. `MOVE_DONE` = 1 only in DONE.
- `MOVE_START` outside IDLE is ignored.
- Read engine (one outstanding read at most):
  - Issues `RD_START` when reads issued < `MOVE_NUM`, no read is outstanding, and buffer count + 1 ≤ `DEPTH`.
  - On `RD_DONE`, pushes `RD_DATA` into the buffer and advances `RD_ADDR` by the source stride.
- Write engine (one outstanding write at most):
  - Issues `WR_START` when the buffer is non-empty and no write is outstanding.
  - `WR_DATA` is the buffer head.
  - On `WR_DONE`, pops the buffer and advances `WR_ADDR` by the destination stride.
- Address arithmetic is modulo 2^`ADDR_W`. Wrap-around is silent.
- Push and pop in the same cycle leave the buffer count unchanged.
- `RD_DONE` or `WR_DONE` with no transaction outstanding is ignored, including in IDLE and DONE.
- Reset, including mid-operation:
  - Returns to IDLE and empties the buffer.
  - Drops outstanding transactions. Their late DONE pulses are ignored.

## Timing

- Reset values: `MOVE_BUSY`, `MOVE_DONE`, `RD_START` and `WR_START` are 0. `RD_ADDR`, `WR_ADDR` and `WR_DATA` are 0.
- All outputs are registered.
- `MOVE_START` sampled at edge N gives `MOVE_BUSY` = 1 and `RD_START` = 1 in cycle N+1.
- `RD_DONE` sampled at edge M:
  - The next `RD_START` can occur at N+1 after M, if space allows.
  - The first `WR_START` occurs in the cycle after M.
- `WR_DONE` sampled at edge K gives the next `WR_START` in the cycle after K, if the buffer is non-empty.
- The final `WR_DONE` at edge K gives `MOVE_DONE` = 1 in cycle K+1 and IDLE at K+2.
- With `MOVE_NUM` = 0, `MOVE_DONE` occurs in cycle N+1.
- A new `MOVE_START` is accepted from cycle K+2 onward.
- Zero-latency responders are legal: a DONE may arrive in the cycle right after its START.

## Configuration

- `BUF_MOVER_STRIDE_EN` defined: the source and destination strides are the `SRC_STRIDE` and `DST_STRIDE` values latched at `MOVE_START`. A stride of 0 is legal and gives a repeated address.
- Not defined: both strides are fixed at `DATA_W`/8 bytes, i.e. contiguous beats. The `SRC_STRIDE` and `DST_STRIDE` ports exist but are ignored.

## Structure

- Package `buf_mover_pkg`: state enum (IDLE, RUN, DONE) and the default values for `DATA_W`, `ADDR_W`, `NUM_W` and `DEPTH`.
- Sub-module `buf_mover_fifo`:
  - Synchronous `DEPTH` × `DATA_W` buffer with push, pop, count, and head output.
  - No bypass; the head is valid from the cycle after the push.
- Top level holds the control FSM, both engines, the address registers and the beat counters.

## Test plan

- `MOVE_NUM` = 3, `SOURCE_ADDR` = 0x100, `DEST_ADDR` = 0x800, one-cycle responders → reads at 0x100/0x110/0x120, writes at 0x800/0x810/0x820 carrying the read data in order, one `MOVE_DONE` pulse.
- `MOVE_NUM` = 0 → no `RD_START` or `WR_START`; `MOVE_DONE` one cycle after `MOVE_START`.
- `MOVE_NUM` = 8, `WR_DONE` withheld 20 cycles → exactly `DEPTH` = 4 reads complete, then reads stall; all 8 beats are written intact after release.
- `SOURCE_ADDR` = 0xFFFFFFF0, `MOVE_NUM` = 2 → second `RD_ADDR` = 0x00000000.
- Reset asserted mid-move with a write outstanding, then a stray `WR_DONE` after release → all outputs 0; no state change; a new move of 1 beat completes normally.
- With `BUF_MOVER_STRIDE_EN`, `SRC_STRIDE` = 0x40, `DST_STRIDE` = 0, `MOVE_NUM` = 3 → reads at S, S+0x40, S+0x80; all three writes to `DEST_ADDR`.
